// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must reach WIDTH itself after the final shift, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: a - b - borrow_in.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor_cell (
    input  logic minuend,
    input  logic subtrahend,
    input  logic borrow_in,
    output logic difference,
    output logic borrow_out
);

    always_comb begin
        difference = minuend ^ subtrahend ^ borrow_in;
        borrow_out = (~minuend & subtrahend) | (~(minuend ^ subtrahend) & borrow_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor A-B-borrow_in, LSB first; SERIAL_SUB_OVERFLOW_EN adds a signed overflow flag.
// Latency: out_valid rises WIDTH+1 edges after acceptance (accept edge included); initiation interval WIDTH+2.
// Backpressure: single operation in flight; result held in DONE until out_ready, in_ready low meanwhile.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             borrow_q;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;
    logic             cell_diff;
    logic             cell_borrow;

    full_subtractor_cell u_cell (
        .minuend    (a_sr[0]),
        .subtrahend (b_sr[0]),
        .borrow_in  (borrow_q),
        .difference (cell_diff),
        .borrow_out (cell_borrow)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = in_valid && in_ready;
    // New difference bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    assign res_nxt  = WIDTH'({cell_diff, res_sr} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow_q   <= 1'b0;
            cnt        <= '0;
            difference <= '0;
            borrow_out <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                a_sr     <= minuend;
                b_sr     <= subtrahend;
                borrow_q <= borrow_in;
                cnt      <= '0;
            end else if (state == SHIFT) begin
                a_sr     <= a_sr >> 1;
                b_sr     <= b_sr >> 1;
                res_sr   <= res_nxt;
                borrow_q <= cell_borrow;
                cnt      <= cnt + CW'(1);
                if (last_bit) begin
                    difference <= res_nxt;
                    borrow_out <= cell_borrow;
                end
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    // On the MSB step borrow_q is the borrow into the sign bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            overflow <= borrow_q ^ cell_borrow;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: randomized and directed operands checked against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] minuend;
    logic [W-1:0] subtrahend;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] difference;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_rdy = 1'b0;
    logic prev_vld = 1'b0;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t sbq[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .difference (difference),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Plain integer arithmetic: unsigned difference, borrow as a compare, signed range test.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        exp_t e;
        int ua, ub, sa, sb, sd;
        ua   = int'(a);
        ub   = int'(b);
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        sd   = sa - sb - int'(bi);
        e.d  = W'(ua - ub - int'(bi));
        e.bo = (ua < ub + int'(bi));
        e.ov = (sd < -(2 ** (W - 1))) || (sd > (2 ** (W - 1)) - 1);
        e.acc = 0;
        return e;
    endfunction

    always @(negedge clk) begin : in_mon
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            e     = model(minuend, subtrahend, borrow_in);
            e.acc = cyc + 1;
            sbq.push_back(e);
        end
    end

    always @(negedge clk) begin : out_mon
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: out_valid=1 difference=%0h with nothing outstanding", difference);
            end else begin
                if (!prev_vld) chk("latency", 64'(cyc - sbq[0].acc), 64'(W));
                chk("difference", difference, sbq[0].d);
                chk("borrow_out", borrow_out, sbq[0].bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
                chk("overflow", overflow, sbq[0].ov);
`endif
                if (out_ready) void'(sbq.pop_front());
            end
        end
        prev_vld <= !rst && out_valid;
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int n = 0;
        in_valid   = 1'b1;
        minuend    = a;
        subtrahend = b;
        borrow_in  = bi;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        minuend    = W'($urandom);
        subtrahend = W'($urandom);
        borrow_in  = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int n;
        bit ghost;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        minuend    = '0;
        subtrahend = '0;
        borrow_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_difference", difference, '0);
        chk("reset_borrow_out", borrow_out, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b1;

        send(8'h5A, 8'h3C, 1'b0);
        send(8'h00, 8'h01, 1'b0);
        send(8'h80, 8'h01, 1'b0);
        send(8'h10, 8'h0F, 1'b1);
        drain();

        // Backpressure in DONE with a new operand set pending.
        out_ready = 1'b0;
        send(8'hC3, 8'h2A, 1'b0);
        in_valid   = 1'b1;
        minuend    = 8'h11;
        subtrahend = 8'h22;
        borrow_in  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        if (!out_valid) fail_now("result_timeout");
        repeat (5) begin
            @(negedge clk);
            chk("held_in_ready", in_ready, 1'b0);
            chk("held_out_valid", out_valid, 1'b1);
            chk("held_queue_depth", 64'(sbq.size()), 64'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 50);
        if (!in_ready) fail_now("reaccept_timeout");
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Reset on the third SHIFT edge discards the operation.
        send(8'h5A, 8'h3C, 1'b0);
        drain();
        send(8'hF0, 8'h0F, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_difference", difference, '0);
        chk("midrst_borrow_out", borrow_out, 1'b0);
        ghost = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) ghost = 1'b1;
        end
        chk("discarded_result", ghost, 1'b0);
        @(posedge clk);
        #1;

        rand_rdy = 1'b1;
        repeat (40) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(W'($urandom), W'($urandom), 1'($urandom));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
